// File: rtl/frac_baud_generator_pkg.sv
// Shared constants and helpers for the fractional baud generator:
// the reset divisor calculation, the minimum legal divisor and a clog2.
package frac_baud_generator_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        LD_NONE,
        LD_ACCEPT,
        LD_REJECT
    } load_kind_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1)
            r++;
        return r;
    endfunction

    function automatic longint unsigned def_int(input longint unsigned clk_hz,
                                                input longint unsigned baud,
                                                input longint unsigned os);
        return clk_hz / (baud * os);
    endfunction

    function automatic longint unsigned def_frac(input longint unsigned clk_hz,
                                                 input longint unsigned baud,
                                                 input longint unsigned os,
                                                 input int unsigned     frac_w);
        return ((clk_hz % (baud * os)) << frac_w) / (baud * os);
    endfunction

endpackage

// File: rtl/frac_baud_generator_if.sv
// Control/tick bundle between the baud generator and its user (RX/TX FSM).
interface frac_baud_generator_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 8
);
    logic              enable;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              load;
    logic              resync;
    logic              tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              cfg_err;

    modport master (
        output enable, div_int, div_frac, load, resync,
        input  tick, mid_tick, bit_tick, cfg_err
    );

    modport slave (
        input  enable, div_int, div_frac, load, resync,
        output tick, mid_tick, bit_tick, cfg_err
    );
endinterface

// File: rtl/frac_baud_generator_tick_subdivider.sv
// Counts oversample ticks modulo OVERSAMPLE and flags the mid-bit and
// end-of-bit ticks; usable standalone at OVERSAMPLE=1 (every tick is both).
module frac_baud_generator_tick_subdivider
    import frac_baud_generator_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_tick,
    input  logic i_resync,
    output logic o_mid,
    output logic o_bit
);
    localparam int unsigned SUB_W = (OVERSAMPLE > 1) ? clog2(OVERSAMPLE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'((OVERSAMPLE > 1) ? (OVERSAMPLE / 2 - 1) : 0);

    logic [SUB_W-1:0] r_sub;
    logic             r_mid;
    logic             r_bit;
    logic             w_evt;

    assign w_evt = i_enable && i_tick && !i_resync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= '0;
            r_mid <= 1'b0;
            r_bit <= 1'b0;
        end else begin
            r_mid <= 1'b0;
            r_bit <= 1'b0;
            if (i_resync) begin
                r_sub <= '0;
            end else if (w_evt) begin
                // Flags reflect the sub value of the tick being issued, not the next one.
                r_sub <= (r_sub == SUB_LAST) ? '0 : r_sub + SUB_W'(1);
                r_mid <= (r_sub == SUB_MID);
                r_bit <= (r_sub == SUB_LAST);
            end
        end
    end

    assign o_mid = r_mid;
    assign o_bit = r_bit;

endmodule

// File: rtl/frac_baud_generator.sv
// Fractional-N oversample tick generator: average period div_int + div_frac/2^FRAC_W,
// glitch-free divisor updates at tick boundaries, and phase resync for start-bit alignment.
module frac_baud_generator
    import frac_baud_generator_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 19200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    frac_baud_generator_if.slave  bus
);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(def_int(CLK_HZ, BAUD, OVERSAMPLE));
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(def_frac(CLK_HZ, BAUD, OVERSAMPLE, FRAC_W));

    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pend;
    logic              r_tick;
    logic              r_cfg_err;

    load_kind_e        w_ld_kind;
    logic              w_last;
    logic              w_evt;
    logic              w_carry;
    logic [FRAC_W-1:0] w_acc_nxt;
    logic              w_mid;
    logic              w_bit;

    always_comb begin
        w_ld_kind = LD_NONE;
        if (bus.load)
            w_ld_kind = (bus.div_int >= DIV_W'(MIN_DIV)) ? LD_ACCEPT : LD_REJECT;
        // cnt == act_int + ext - 1 without widening: act_int >= 2 so no underflow.
        w_last = r_ext ? (r_cnt == r_act_int) : (r_cnt == r_act_int - DIV_W'(1));
        w_evt  = bus.enable && w_last && !bus.resync;
        {w_carry, w_acc_nxt} = {1'b0, r_acc} + {1'b0, r_act_frac};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ext      <= 1'b0;
            r_act_int  <= DEF_INT;
            r_act_frac <= DEF_FRAC;
            r_sh_int   <= DEF_INT;
            r_sh_frac  <= DEF_FRAC;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (bus.resync) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ext <= 1'b0;
                if (w_ld_kind == LD_ACCEPT) begin
                    r_act_int  <= bus.div_int;
                    r_act_frac <= bus.div_frac;
                    r_pend     <= 1'b0;
                end
            end else begin
                if (w_evt) begin
                    r_cnt  <= '0;
                    r_acc  <= w_acc_nxt;
                    r_ext  <= w_carry;
                    r_tick <= 1'b1;
                    if (r_pend) begin
                        r_act_int  <= r_sh_int;
                        r_act_frac <= r_sh_frac;
                        r_pend     <= 1'b0;
                    end
                end else if (bus.enable) begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
                // A load coincident with a boundary lands in the shadow for the following one.
                if (w_ld_kind == LD_ACCEPT) begin
                    r_sh_int  <= bus.div_int;
                    r_sh_frac <= bus.div_frac;
                    r_pend    <= 1'b1;
                end
            end
            if (w_ld_kind != LD_NONE)
                r_cfg_err <= (w_ld_kind == LD_REJECT);
        end
    end

    frac_baud_generator_tick_subdivider #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sub (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (bus.enable),
        .i_tick   (w_last),
        .i_resync (bus.resync),
        .o_mid    (w_mid),
        .o_bit    (w_bit)
    );

    assign bus.tick     = r_tick;
    assign bus.mid_tick = w_mid;
    assign bus.bit_tick = w_bit;
    assign bus.cfg_err  = r_cfg_err;

endmodule
